// File: rtl/trojan_pkg.sv
// Shared types and constants for the sequential trojan trigger family.
// Holds the FSM state encoding, default compare constants and parameter legality checks.
package trojan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } trig_state_t;

  localparam logic [7:0] DEF_MATCH_PATTERN = 8'hFF;
  localparam logic [7:0] DEF_CARE_MASK     = 8'hFF;

  // Threshold must be reachable by the counter and non-zero.
  function automatic bit thresh_legal(input int thresh, input int cnt_w);
    return (thresh >= 1) && (thresh <= ((1 << cnt_w) - 1));
  endfunction

  function automatic bit fire_cycles_legal(input int fire_cycles);
    return (fire_cycles >= 1) && (fire_cycles <= 255);
  endfunction

endpackage

// File: rtl/trig_match.sv
// Masked equality comparator: match is high when every cared-for bit equals the pattern.
module trig_match #(
  parameter int W = 8
) (
  input  logic [W-1:0] in_vec,
  input  logic [W-1:0] pattern,
  input  logic [W-1:0] mask,
  output logic         match
);

  assign match = (((in_vec ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_trojan_trigger.sv
// Counter/FSM trigger: counts masked pattern matches and raises a registered trigger at threshold.
// Trigger_out1 drives the downstream payload XOR; fired mirrors it for observation.
module seq_trojan_trigger
  import trojan_pkg::*;
#(
  parameter int              N_IN          = 8,
  parameter logic [N_IN-1:0] MATCH_PATTERN = N_IN'(DEF_MATCH_PATTERN),
  parameter logic [N_IN-1:0] CARE_MASK     = N_IN'(DEF_CARE_MASK),
  parameter int              CNT_W         = 4,
  parameter int              COUNT_THRESH  = 4,
  parameter int              CONSECUTIVE   = 1,
  parameter int              STICKY        = 1,
  parameter int              FIRE_CYCLES   = 1
) (
  input  logic            CK,
  input  logic            RST,
  input  logic            EN,
  input  logic [N_IN-1:0] I,
  output logic            Trigger_out1,
  output logic [CNT_W-1:0] hit_cnt,
  output logic            fired
);

  generate
    if (!thresh_legal(COUNT_THRESH, CNT_W)) begin : g_bad_thresh
      $error("COUNT_THRESH out of range for CNT_W");
    end
    if (!fire_cycles_legal(FIRE_CYCLES)) begin : g_bad_fire
      $error("FIRE_CYCLES out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(COUNT_THRESH);
  localparam logic [7:0]       FIRE_C   = 8'(FIRE_CYCLES);

  trig_state_t      state;
  logic [7:0]       fire_tmr;
  logic             match;
  logic [CNT_W-1:0] cnt_inc;

  trig_match #(
    .W(N_IN)
  ) u_match (
    .in_vec (I),
    .pattern(MATCH_PATTERN),
    .mask   (CARE_MASK),
    .match  (match)
  );

  // Cannot overflow: the FSM leaves COUNT once cnt_inc reaches the threshold.
  assign cnt_inc = hit_cnt + CNT_W'(1);

  always_ff @(posedge CK) begin
    if (RST) begin
      state        <= IDLE;
      hit_cnt      <= '0;
      fire_tmr     <= '0;
      Trigger_out1 <= 1'b0;
    end else if (EN) begin
      case (state)
        IDLE: begin
          if (match) begin
            if (COUNT_THRESH == 1) begin
              state        <= FIRED;
              hit_cnt      <= THRESH_C;
              Trigger_out1 <= 1'b1;
            end else begin
              state   <= COUNT;
              hit_cnt <= CNT_W'(1);
            end
          end
        end
        COUNT: begin
          if (match) begin
            if (cnt_inc == THRESH_C) begin
              state        <= FIRED;
              hit_cnt      <= THRESH_C;
              Trigger_out1 <= 1'b1;
            end else begin
              hit_cnt <= cnt_inc;
            end
          end else if (CONSECUTIVE != 0) begin
            state   <= IDLE;
            hit_cnt <= '0;
          end
        end
        FIRED: begin
          // Pulse mode: the exit cycle ignores I so a match there is not re-counted.
          if (STICKY == 0) begin
            if (fire_tmr + 8'd1 == FIRE_C) begin
              state        <= IDLE;
              hit_cnt      <= '0;
              fire_tmr     <= '0;
              Trigger_out1 <= 1'b0;
            end else begin
              fire_tmr <= fire_tmr + 8'd1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          hit_cnt      <= '0;
          fire_tmr     <= '0;
          Trigger_out1 <= 1'b0;
        end
      endcase
    end
  end

  assign fired = Trigger_out1;

endmodule

// File: doc/seq_trojan_trigger.md
Name: seq_trojan_trigger

Overview:
- Sequential trigger stage that sits directly upstream of the payload XOR.
- Watches a vector of trigger nets, compares it each cycle against a rare pattern under a care mask, and counts occurrences.
- Drives Trigger_out1 into the payload gate once the count reaches a threshold.
- Replaces the purely combinational AND-tree trigger with a counter/FSM trigger for sequential benchmark insertion (s27-class netlists).

Parameters:
- N_IN, 8, number of trigger nets (width of I).
- MATCH_PATTERN, 8'hFF, required value of each trigger net.
- CARE_MASK, 8'hFF, 1 = bit participates in compare; 0 = don't-care.
- CNT_W, 4, occurrence counter width.
- COUNT_THRESH, 4, matches needed to fire; legal range 1..2^CNT_W-1 (elaboration error otherwise).
- CONSECUTIVE, 1, 1 = a miss clears the count; 0 = cumulative count, a miss holds it.
- STICKY, 1, 1 = stays fired until RST; 0 = fires for FIRE_CYCLES, then re-arms.
- FIRE_CYCLES, 1, pulse length when STICKY=0; range 1..255.

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  count enable; low freezes state, counter and fire timer.
- I  input  N_IN  trigger nets (I1..I8 mapping as inserted).
- Trigger_out1  output  1  registered trigger, feeds payload XOR.
- hit_cnt  output  CNT_W  current occurrence count (debug/verification).
- fired  output  1  high while FSM is in FIRED (equal to Trigger_out1).

Behaviour:
- Single clock domain. Only CK is used; reset is synchronous, active-high and sampled on the CK rising edge.
- match = (((I ^ MATCH_PATTERN) & CARE_MASK) == 0); combinational; only sampled when EN=1.
- Reset values: state=IDLE, hit_cnt=0, fire timer=0, Trigger_out1=0, fired=0. RST overrides EN and all other inputs, including mid-count and while FIRED.
- States:
  - IDLE: hit_cnt=0. On EN & match: if COUNT_THRESH==1 go to FIRED, else go to COUNT with hit_cnt=1. On no match, stay.
  - COUNT, on EN & match:
    - If hit_cnt+1 == COUNT_THRESH, go to FIRED and hold hit_cnt=COUNT_THRESH.
    - Otherwise hit_cnt++.
  - COUNT, on EN & !match:
    - CONSECUTIVE=1: go to IDLE, hit_cnt=0.
    - CONSECUTIVE=0: hold.
  - FIRED: Trigger_out1=1.
    - STICKY=1: remain until RST; I is ignored.
    - STICKY=0: fire timer counts EN cycles; after FIRE_CYCLES cycles in FIRED, go to IDLE with hit_cnt=0. A match on that exit cycle is ignored (no same-cycle re-count).
- Latency: the match on the edge that completes COUNT_THRESH occurrences causes Trigger_out1=1 in the cycle immediately after that edge (one register). No combinational path from I to Trigger_out1.
- EN=0: all state is frozen, and Trigger_out1 holds its value (a fired trigger stays asserted while frozen).
- Counter never wraps: the FSM leaves COUNT at the threshold, so hit_cnt ≤ COUNT_THRESH always.
- X on I while EN=0 must not disturb state.
- Payload connection (outside this block): victim_x = Trigger_out1 ^ victim.

Decomposition:
- Package trojan_pkg holds:
  - state enum trig_state_t {IDLE, COUNT, FIRED};
  - default MATCH_PATTERN/CARE_MASK constants;
  - a function checking the legality of COUNT_THRESH.
- One natural sub-module, trig_match: a parameterised masked comparator (I, pattern, mask -> match). It is reused later by combinational trigger variants.
- FSM, counter and fire timer stay in seq_trojan_trigger.

Test Plan:
1. Reset: RST=1 for 2 cycles with I=8'hFF, EN=1 -> Trigger_out1=0, hit_cnt=0 on every cycle; release and check the first count starts from 0.
2. Consecutive fire (defaults): I=8'hFF for 4 cycles, EN=1 -> hit_cnt 1,2,3; Trigger_out1=1 on cycle 5; still 1 after 20 cycles of I=8'h00.
3. Miss clears (CONSECUTIVE=1): I=FF,FF,FF,00,FF -> hit_cnt 1,2,3,0,1; Trigger_out1 stays 0.
4. Cumulative (CONSECUTIVE=0): I=FF,00,FF,00,FF,FF -> hit_cnt 1,1,2,2,3, then Trigger_out1=1 in the next cycle.
5. Pulse mode (STICKY=0, FIRE_CYCLES=3, COUNT_THRESH=2): two matches -> Trigger_out1 high exactly 3 cycles, then 0 with hit_cnt=0; two further matches fire again.
6. EN freeze and reset mid-op:
   - 2 matches, then EN=0 for 5 cycles with I=FF -> hit_cnt stays 2.
   - EN=1 plus 2 matches -> fire.
   - RST during FIRED -> Trigger_out1=0 the next cycle.
   - CARE_MASK=8'h0F with I=8'h0F -> counts as a match.
